// File: rtl/afifo_axis_packetizer_if.sv
// FIFO read port and AXI-Stream master bundle for the capture-path packetizer.
// The master side is the packetizer; the slave side is the FIFO plus DMA sink.
interface afifo_axis_packetizer_if;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic [9:0]  fifo_rd_data_count;
    logic        fifo_rd_en;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_data_count,
        input  m_axis_tready,
        output fifo_rd_en,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_data_count,
        output m_axis_tready,
        input  fifo_rd_en,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );
endinterface

// File: rtl/afifo_axis_packetizer.sv
// Read-side packetizer: waits for a full packet in the async FIFO, reads it out,
// packs byte pairs into 16-bit AXIS words and tags the final word with tlast.
module afifo_axis_packetizer #(
    parameter int PKT_BYTES = 256
) (
    input  logic                    rd_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    afifo_axis_packetizer_if.master bus,
    output logic [15:0]             pkt_count,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    localparam logic [9:0] PKT     = 10'(PKT_BYTES);
    localparam logic [9:0] LAST_RD = 10'(PKT_BYTES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_rdIssued;
    logic [9:0]  r_capCount;
    logic [2:0]  r_credit;
    logic        r_rdValid;
    logic [7:0]  r_hi;
    logic [15:0] r_data0;
    logic [15:0] r_data1;
    logic        r_last0;
    logic        r_last1;
    logic [1:0]  r_wordCount;

    logic        w_rdEn;
    logic        w_start;
    logic        w_pop;
    logic        w_push;
    logic        w_pushLast;
    logic        w_pktDone;
    logic [15:0] w_word;

    // Credit caps bytes in flight plus buffered at 4, so the 2-word buffer never overflows
    assign w_rdEn     = (r_state == STREAM) && (r_rdIssued < PKT) &&
                        !bus.fifo_empty && (r_credit < 3'd4);
    assign w_start    = (r_state == IDLE) && enable && (bus.fifo_rd_data_count >= PKT);
    assign w_pop      = (r_wordCount != 2'd0) && bus.m_axis_tready;
    assign w_push     = r_rdValid && r_capCount[0];
    assign w_pushLast = (r_capCount == LAST_RD);
    assign w_pktDone  = (r_state == DRAIN) && w_pop && r_last0;
    assign w_word     = {r_hi, bus.fifo_dout};

    assign bus.fifo_rd_en    = w_rdEn;
    assign bus.m_axis_tdata  = r_data0;
    assign bus.m_axis_tvalid = (r_wordCount != 2'd0);
    assign bus.m_axis_tlast  = r_last0 && (r_wordCount != 2'd0);
    assign busy              = (r_state != IDLE);

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = STREAM;
            STREAM:  if (w_rdEn && (r_rdIssued == LAST_RD)) w_next = DRAIN;
            DRAIN:   if (w_pktDone) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdIssued <= '0;
            r_capCount <= '0;
            r_credit   <= '0;
            r_rdValid  <= 1'b0;
            r_hi       <= '0;
        end else begin
            r_rdValid <= w_rdEn;
            if (w_start) begin
                r_rdIssued <= '0;
                r_capCount <= '0;
            end else begin
                if (w_rdEn) r_rdIssued <= r_rdIssued + 10'd1;
                if (r_rdValid) r_capCount <= r_capCount + 10'd1;
            end
            if (r_rdValid && !r_capCount[0]) r_hi <= bus.fifo_dout;
            r_credit <= r_credit + {2'b00, w_rdEn} - (w_pop ? 3'd2 : 3'd0);
        end
    end

    // Head entry drives the bus and only changes on a pop or a push into an empty buffer
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0     <= '0;
            r_data1     <= '0;
            r_last0     <= 1'b0;
            r_last1     <= 1'b0;
            r_wordCount <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_wordCount == 2'd0) begin
                        r_data0 <= w_word;
                        r_last0 <= w_pushLast;
                    end else begin
                        r_data1 <= w_word;
                        r_last1 <= w_pushLast;
                    end
                    r_wordCount <= r_wordCount + 2'd1;
                end
                2'b01: begin
                    r_data0     <= r_data1;
                    r_last0     <= r_last1;
                    r_wordCount <= r_wordCount - 2'd1;
                end
                2'b11: begin
                    if (r_wordCount == 2'd1) begin
                        r_data0 <= w_word;
                        r_last0 <= w_pushLast;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= w_word;
                        r_last1 <= w_pushLast;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (w_pktDone) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_afifo_axis_packetizer.sv
// Bench for the packetizer: an 8-byte instance for directed cases and a 256-byte
// instance for random backpressure, each fed by a FIFO model and a word scoreboard.
module tb_afifo_axis_packetizer;

    logic rd_clk = 1'b0;
    logic rst_n  = 1'b0;
    logic enA    = 1'b0;
    logic enB    = 1'b0;
    logic readyLevelA = 1'b1;
    logic randB  = 1'b0;

    logic [15:0] pktA;
    logic [15:0] pktB;
    logic        busyA;
    logic        busyB;

    int nChecks = 0;
    int nFails  = 0;

    afifo_axis_packetizer_if ifA ();
    afifo_axis_packetizer_if ifB ();

    afifo_axis_packetizer #(.PKT_BYTES(8)) dutA (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enA), .bus(ifA.master),
        .pkt_count(pktA), .busy(busyA)
    );

    afifo_axis_packetizer #(.PKT_BYTES(256)) dutB (
        .rd_clk(rd_clk), .rst_n(rst_n), .enable(enB), .bus(ifB.master),
        .pkt_count(pktB), .busy(busyB)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO models: bench writes at wr pointer, DUT reads with one cycle of latency
    logic [7:0] memA [0:255];
    logic [7:0] memB [0:32767];
    int wrA = 0;
    int rdA = 0;
    int wrB = 0;
    int rdB = 0;

    assign ifA.fifo_empty         = (wrA == rdA);
    assign ifA.fifo_rd_data_count = ((wrA - rdA) > 1023) ? 10'd1023 : 10'(wrA - rdA);
    assign ifB.fifo_empty         = (wrB == rdB);
    assign ifB.fifo_rd_data_count = ((wrB - rdB) > 1023) ? 10'd1023 : 10'(wrB - rdB);

    always @(posedge rd_clk) begin
        if (ifA.fifo_rd_en) begin
            ifA.fifo_dout <= memA[rdA];
            rdA <= rdA + 1;
        end
        if (ifB.fifo_rd_en) begin
            ifB.fifo_dout <= memB[rdB];
            rdB <= rdB + 1;
        end
    end

    always @(posedge rd_clk) begin
        #1;
        ifA.m_axis_tready = readyLevelA;
        ifB.m_axis_tready = randB ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Scoreboards hold {tlast, tdata}
    logic [16:0] expA [$];
    logic [16:0] expB [$];
    logic [7:0]  hiA;
    logic [7:0]  hiB;
    int idxA = 0;
    int idxB = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task addExpA(input logic [7:0] b);
        if (idxA[0] == 1'b0) hiA = b;
        else expA.push_back({(idxA == 7), hiA, b});
        idxA = (idxA + 1) % 8;
    endtask

    task addExpB(input logic [7:0] b);
        if (idxB[0] == 1'b0) hiB = b;
        else expB.push_back({(idxB == 255), hiB, b});
        idxB = (idxB + 1) % 256;
    endtask

    task applyStimulusA(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            memA[wrA] = first + 8'(i);
            addExpA(first + 8'(i));
            wrA = wrA + 1;
        end
    endtask

    task applyStimulusB(input int n);
        for (int i = 0; i < n; i++) begin
            memB[wrB] = 8'(i);
            addExpB(8'(i));
            wrB = wrB + 1;
        end
    endtask

    task automatic waitPktA(input logic [15:0] target, input int budget, input string tag);
        int c = 0;
        while (pktA != target && c < budget) begin
            @(negedge rd_clk);
            c++;
        end
        checkOutput(tag, 32'(pktA), 32'(target));
    endtask

    task automatic waitBusyA(input int budget);
        int c = 0;
        while (!busyA && c < budget) begin
            @(negedge rd_clk);
            c++;
        end
        checkOutput("A busy after start", 32'(busyA), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rd_en"},  32'(ifA.fifo_rd_en),    32'd0);
        checkOutput({tag, " tvalid"}, 32'(ifA.m_axis_tvalid), 32'd0);
        checkOutput({tag, " tlast"},  32'(ifA.m_axis_tlast),  32'd0);
        checkOutput({tag, " tdata"},  32'(ifA.m_axis_tdata),  32'd0);
        checkOutput({tag, " pkt_count"}, 32'(pktA), 32'd0);
        checkOutput({tag, " busy"},   32'(busyA), 32'd0);
    endtask

    // Word monitors: pop the scoreboard on every accepted beat and check hold-while-stalled
    logic        holdA = 1'b0;
    logic        holdB = 1'b0;
    logic [16:0] prevA;
    logic [16:0] prevB;

    always @(negedge rd_clk) begin
        if (rst_n && ifA.m_axis_tvalid) begin
            if (holdA) checkOutput("A hold while stalled", {15'd0, ifA.m_axis_tlast, ifA.m_axis_tdata}, {15'd0, prevA});
            if (ifA.m_axis_tready) begin
                if (expA.size() == 0) begin
                    checkOutput("A unexpected beat", 32'(ifA.m_axis_tdata), 32'hDEAD);
                end else begin
                    checkOutput("A tdata", 32'(ifA.m_axis_tdata), 32'(expA[0][15:0]));
                    checkOutput("A tlast", 32'(ifA.m_axis_tlast), 32'(expA[0][16]));
                    void'(expA.pop_front());
                end
            end
        end
        holdA <= rst_n && ifA.m_axis_tvalid && !ifA.m_axis_tready;
        prevA <= {ifA.m_axis_tlast, ifA.m_axis_tdata};
    end

    always @(negedge rd_clk) begin
        if (rst_n && ifB.m_axis_tvalid) begin
            if (holdB) checkOutput("B hold while stalled", {15'd0, ifB.m_axis_tlast, ifB.m_axis_tdata}, {15'd0, prevB});
            if (ifB.m_axis_tready) begin
                if (expB.size() == 0) begin
                    checkOutput("B unexpected beat", 32'(ifB.m_axis_tdata), 32'hDEAD);
                end else begin
                    checkOutput("B tdata", 32'(ifB.m_axis_tdata), 32'(expB[0][15:0]));
                    checkOutput("B tlast", 32'(ifB.m_axis_tlast), 32'(expB[0][16]));
                    void'(expB.pop_front());
                end
            end
        end
        holdB <= rst_n && ifB.m_axis_tvalid && !ifB.m_axis_tready;
        prevB <= {ifB.m_axis_tlast, ifB.m_axis_tdata};
    end

    initial begin
        int t0;
        int t1;
        int rdCount;
        int beats;
        int c;

        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        checkResetOutputs("reset");
        checkOutput("B reset pkt_count", 32'(pktB), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge rd_clk);

        $display("[TB] basic packet");
        applyStimulusA(8, 8'h01);
        @(posedge rd_clk);
        #1 enA = 1'b1;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 100 && pktA != 16'd1; i++) begin
            @(negedge rd_clk);
            if (ifA.fifo_rd_en && t0 < 0) t0 = i;
            if (ifA.m_axis_tvalid && t1 < 0) t1 = i;
        end
        checkOutput("A first-word latency", 32'(t1 - t0), 32'd3);
        checkOutput("A pkt_count basic", 32'(pktA), 32'd1);
        checkOutput("A busy after packet", 32'(busyA), 32'd0);

        $display("[TB] threshold");
        applyStimulusA(6, 8'h11);
        rdCount = 0;
        repeat (10) begin
            @(negedge rd_clk);
            if (ifA.fifo_rd_en) rdCount++;
        end
        checkOutput("A rd_en below threshold", 32'(rdCount), 32'd0);
        checkOutput("A busy below threshold", 32'(busyA), 32'd0);
        applyStimulusA(2, 8'h17);
        waitPktA(16'd2, 100, "A pkt_count threshold");

        $display("[TB] backpressure");
        readyLevelA = 1'b0;
        @(posedge rd_clk);
        applyStimulusA(8, 8'h21);
        @(negedge rd_clk);
        waitBusyA(20);
        rdCount = 0;
        repeat (20) begin
            if (ifA.fifo_rd_en) rdCount++;
            @(negedge rd_clk);
        end
        checkOutput("A rd_en pulses under backpressure", 32'(rdCount), 32'd4);
        readyLevelA = 1'b1;
        waitPktA(16'd3, 100, "A pkt_count backpressure");

        $display("[TB] enable dropped mid-packet");
        enA = 1'b0;
        applyStimulusA(16, 8'h41);
        @(posedge rd_clk);
        #1 enA = 1'b1;
        @(negedge rd_clk);
        waitBusyA(20);
        enA = 1'b0;
        waitPktA(16'd4, 100, "A pkt_count enable drop");
        rdCount = 0;
        repeat (20) begin
            @(negedge rd_clk);
            if (ifA.fifo_rd_en || busyA) rdCount++;
        end
        checkOutput("A no restart with enable low", 32'(rdCount), 32'd0);

        $display("[TB] reset mid-packet");
        applyStimulusA(8, 8'h61);
        @(posedge rd_clk);
        #1 enA = 1'b1;
        beats = 0;
        c = 0;
        while (beats < 3 && c < 100) begin
            @(negedge rd_clk);
            if (ifA.m_axis_tvalid && ifA.m_axis_tready) beats++;
            c++;
        end
        checkOutput("A beats before reset", 32'(beats), 32'd3);
        @(posedge rd_clk);
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("mid-packet reset");
        expA.delete();
        idxA = 0;
        for (int i = rdA; i < wrA; i++) addExpA(memA[i]);
        @(negedge rd_clk);
        rst_n = 1'b1;
        waitPktA(16'd1, 100, "A pkt_count after reset");
        checkOutput("A scoreboard drained", 32'(expA.size()), 32'd0);
        enA = 1'b0;

        $display("[TB] random tready, 100 packets of 256 bytes");
        applyStimulusB(25600);
        randB = 1'b1;
        @(posedge rd_clk);
        #1 enB = 1'b1;
        c = 0;
        while (pktB != 16'd100 && c < 70000) begin
            @(negedge rd_clk);
            c++;
        end
        checkOutput("B pkt_count", 32'(pktB), 32'd100);
        checkOutput("B scoreboard drained", 32'(expB.size()), 32'd0);
        repeat (5) @(negedge rd_clk);
        checkOutput("B busy at end", 32'(busyB), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
